fetch_buffer_unit: RTL

//  Parametrised instruction-fetch front end for the pipelined core.
//  - Owns the PC and drives the asynchronous-read instruction memory.
//  - Queues fetched {pc, pc_next, instr} tuples in a BUF_DEPTH-entry FIFO.
//  - Presents the queue head to decode via a valid/ready handshake, so decode stalls never drop instructions.
//  - Taken branches/jumps from execute redirect the PC and flush everything queued.

---
 rtl/fetch_buffer_unit_if.sv | 40 ++++
 rtl/fetch_buffer_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_buffer_unit_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for fetch_buffer_unit.
// master is the fetch unit's view; slave is the memory/execute/decode side.
interface fetch_buffer_unit_if #(
  parameter int PC_WIDTH    = 9,
  parameter int INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [PC_WIDTH-1:0]    out_pc_next;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_next
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_next
  );
endinterface

// File: rtl/fetch_buffer_unit.sv
// Instruction fetch front end: owns the PC, queues {pc, pc_next, instr} in a BUF_DEPTH FIFO.
// Latency: fetched word reaches the head one cycle later; a redirect target shows two cycles later.
// Backpressure: out_ready=0 fills the FIFO, then the PC holds. FETCH_PERF_EN adds perf counters.
module fetch_buffer_unit #(
  parameter int PC_WIDTH    = 9,
  parameter int INSTR_WIDTH = 32,
  parameter int BUF_DEPTH   = 2,
  parameter int PC_STEP     = 1,
  parameter int RESET_PC    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_buffer_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushed
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PC_WIDTH-1:0] STEP_C  = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] RST_PC  = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0]    r_pc;
  logic [CNT_W-1:0]       r_count;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PC_WIDTH-1:0]    r_fifo_pc      [BUF_DEPTH];
  logic [PC_WIDTH-1:0]    r_fifo_pc_next [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0] r_fifo_instr   [BUF_DEPTH];

  logic [PC_WIDTH-1:0]    w_pc_next;
  logic                   w_pop;
  logic                   w_push;

  assign w_pc_next = r_pc + STEP_C;
  assign w_pop     = (r_count != '0) & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push    = ~bus.redirect_valid & ((r_count < DEPTH_C) | w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RST_PC;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      r_pc     <= bus.redirect_pc;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= w_pc_next;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries are cleared on reset so the head ports are never X.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_fifo_pc[i]      <= '0;
        r_fifo_pc_next[i] <= '0;
        r_fifo_instr[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wr_ptr]      <= r_pc;
      r_fifo_pc_next[r_wr_ptr] <= w_pc_next;
      r_fifo_instr[r_wr_ptr]   <= bus.imem_data;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.out_valid   = (r_count != '0);
  assign bus.out_instr   = r_fifo_instr[r_rd_ptr];
  assign bus.out_pc      = r_fifo_pc[r_rd_ptr];
  assign bus.out_pc_next = r_fifo_pc_next[r_rd_ptr];

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (bus.redirect_valid) begin
        r_perf_flushed <= r_perf_flushed + 32'(r_count);
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule
